// File: rtl/l1a_window_readout.sv
// rtl/l1a_window_readout.sv - level-1 accept window capture into a header/data/trailer readout FIFO
module l1a_window_readout #(
  parameter int DW    = 34,
  parameter int DEPTH = 32
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [DW-1:0] din,
  input  logic          din_valid,
  input  logic          l1a,
  input  logic [3:0]    l1a_window,
  input  logic          trig_stop,
  output logic [DW-1:0] dout,
  output logic [1:0]    dout_type,
  output logic          dout_valid,
  input  logic          dout_ready,
  output logic          busy,
  output logic [7:0]    l1a_cnt,
  output logic          overflow
);

  localparam int AW = $clog2(DEPTH);
  localparam int FW = DW + 2;

  typedef enum logic [1:0] {S_IDLE, S_HDR, S_WIN, S_TRL} state_t;

  state_t        state, state_nxt;
  logic [FW-1:0] mem [DEPTH];
  logic [AW:0]   wr_ptr, rd_ptr, occ, free_cnt, need;
  logic [3:0]    w_req, w_lat, win_left;
  logic [7:0]    cnt_lat;
  logic [4:0]    frame_cnt;
  logic          push, push_en, pop, empty, full, accept;
  logic [FW-1:0] push_word;

  // Window length 0 is the shorthand for the 10-frame default.
  assign w_req    = (l1a_window == 4'd0) ? 4'd10 : l1a_window;
  assign occ      = wr_ptr - rd_ptr;
  assign free_cnt = (AW+1)'(DEPTH) - occ;
  assign need     = (AW+1)'(w_req) + (AW+1)'(2);
  assign accept   = l1a && (state == S_IDLE) && (free_cnt >= need);

  assign empty      = (wr_ptr == rd_ptr);
  assign full       = (occ == (AW+1)'(DEPTH));
  assign dout_valid = !empty;
  assign pop        = dout_valid && dout_ready;
  assign push_en    = push && !full;
  assign dout       = empty ? '0 : mem[rd_ptr[AW-1:0]][DW-1:0];
  assign dout_type  = empty ? 2'b00 : mem[rd_ptr[AW-1:0]][FW-1:DW];
  assign busy       = (state != S_IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      state <= S_IDLE;
    else if (trig_stop)
      state <= S_IDLE;
    else
      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    push      = 1'b0;
    push_word = '0;
    case (state)
      S_IDLE: if (accept) state_nxt = S_HDR;
      S_HDR: begin
        push      = 1'b1;
        push_word = {2'b11, {(DW-8){1'b0}}, cnt_lat};
        state_nxt = S_WIN;
      end
      S_WIN: begin
        push      = din_valid;
        push_word = {2'b01, din};
        if (win_left == 4'd1) state_nxt = S_TRL;
      end
      S_TRL: begin
        push      = 1'b1;
        push_word = {2'b10, {(DW-13){1'b0}}, cnt_lat, frame_cnt};
        state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // Payload storage carries no reset; the pointers alone define what is valid.
  always_ff @(posedge clk) begin
    if (push_en) mem[wr_ptr[AW-1:0]] <= push_word;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      l1a_cnt   <= '0;
      overflow  <= 1'b0;
      frame_cnt <= '0;
      w_lat     <= '0;
      win_left  <= '0;
      cnt_lat   <= '0;
    end else if (trig_stop) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      l1a_cnt   <= '0;
      overflow  <= 1'b0;
      frame_cnt <= '0;
    end else begin
      if (l1a) begin
        l1a_cnt <= l1a_cnt + 8'd1;
        if (!accept) overflow <= 1'b1;
      end
      if (accept) begin
        w_lat   <= w_req;
        cnt_lat <= l1a_cnt;
      end
      if (state == S_HDR) begin
        win_left  <= w_lat;
        frame_cnt <= '0;
      end
      if (state == S_WIN) begin
        win_left <= win_left - 4'd1;
        if (din_valid) frame_cnt <= frame_cnt + 5'd1;
      end
      if (push_en) wr_ptr <= wr_ptr + 1'b1;
      if (pop)     rd_ptr <= rd_ptr + 1'b1;
    end
  end

endmodule

// File: tb/tb_l1a_window_readout.sv
// tb/tb_l1a_window_readout.sv - directed bench for l1a_window_readout
module tb_l1a_window_readout;
  localparam int DW = 34;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [DW-1:0] din;
  logic          din_valid;
  logic          l1a;
  logic [3:0]    l1a_window;
  logic          trig_stop;
  logic [DW-1:0] dout;
  logic [1:0]    dout_type;
  logic          dout_valid;
  logic          dout_ready;
  logic          busy;
  logic [7:0]    l1a_cnt;
  logic          overflow;

  int total = 0;
  int bad   = 0;
  logic [DW+1:0] q [$];

  l1a_window_readout #(.DW(DW), .DEPTH(32)) dut (
    .clk(clk), .rst_n(rst_n), .din(din), .din_valid(din_valid), .l1a(l1a),
    .l1a_window(l1a_window), .trig_stop(trig_stop), .dout(dout),
    .dout_type(dout_type), .dout_valid(dout_valid), .dout_ready(dout_ready),
    .busy(busy), .l1a_cnt(l1a_cnt), .overflow(overflow)
  );

  always #5 clk = ~clk;

  // Words accepted by the consumer, captured mid-cycle ahead of the popping edge.
  always @(negedge clk)
    if (rst_n && dout_valid && dout_ready) q.push_back({dout_type, dout});

  function automatic logic [DW+1:0] mk(input logic [1:0] t, input int p);
    return {t, DW'(p)};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic flush();
    trig_stop = 1'b1;
    tick();
    trig_stop = 1'b0;
    q.delete();
  endtask

  task automatic test_reset();
    rst_n = 1'b0; din = '0; din_valid = 0; l1a = 0; l1a_window = 0;
    trig_stop = 0; dout_ready = 0;
    #12;
    total++; if (dout_valid !== 1'b0) begin bad++; $display("FAIL reset_dout_valid got=%b exp=0", dout_valid); end
    total++; if (dout !== '0 || dout_type !== 2'b00) begin bad++; $display("FAIL reset_dout got=%h/%b exp=0/0", dout, dout_type); end
    total++; if (busy !== 1'b0 || overflow !== 1'b0) begin bad++; $display("FAIL reset_flags busy=%b ovf=%b exp=0/0", busy, overflow); end
    total++; if (l1a_cnt !== 8'd0) begin bad++; $display("FAIL reset_l1a_cnt got=%0d exp=0", l1a_cnt); end
    @(negedge clk);
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_basic();
    logic [DW+1:0] exp [5];
    exp[0] = mk(2'b11, 0); exp[1] = mk(2'b01, 1); exp[2] = mk(2'b01, 2);
    exp[3] = mk(2'b01, 3); exp[4] = mk(2'b10, 3);
    q.delete();
    dout_ready = 1; l1a_window = 4'd3; l1a = 1;
    tick();
    l1a = 0;
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL basic_busy got=%b exp=1", busy); end
    tick();
    total++; if (dout_valid !== 1'b1 || dout_type !== 2'b11 || dout !== '0) begin bad++; $display("FAIL basic_hdr_fwft got=%b/%b/%h exp=1/11/0", dout_valid, dout_type, dout); end
    for (int i = 1; i <= 3; i++) begin din = DW'(i); din_valid = 1; tick(); end
    din_valid = 0;
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL basic_trl_busy got=%b exp=1", busy); end
    tick();
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL basic_idle got=%b exp=0", busy); end
    repeat (4) tick();
    total++; if (q.size() != 5) begin bad++; $display("FAIL basic_count got=%0d exp=5", q.size()); end
    for (int i = 0; i < 5; i++) begin
      total++;
      if (i >= q.size() || q[i] !== exp[i]) begin bad++; $display("FAIL basic_word%0d got=%h exp=%h", i, (i < q.size()) ? q[i] : '0, exp[i]); end
    end
    total++; if (l1a_cnt !== 8'd1 || overflow !== 1'b0) begin bad++; $display("FAIL basic_cnt got=%0d/%b exp=1/0", l1a_cnt, overflow); end
  endtask

  task automatic test_window0();
    logic [DW+1:0] exp [7];
    exp[0] = mk(2'b11, 1);
    for (int i = 0; i < 5; i++) exp[i+1] = mk(2'b01, 10 + 2*i);
    exp[6] = mk(2'b10, 37);
    q.delete();
    dout_ready = 1; l1a_window = 4'd0; l1a = 1;
    tick();
    l1a = 0;
    tick();
    for (int i = 0; i < 10; i++) begin din = DW'(10 + i); din_valid = (i % 2 == 0); tick(); end
    din_valid = 0;
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL win0_len_busy got=%b exp=1", busy); end
    tick();
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL win0_end got=%b exp=0", busy); end
    repeat (4) tick();
    total++; if (q.size() != 7) begin bad++; $display("FAIL win0_count got=%0d exp=7", q.size()); end
    for (int i = 0; i < 7; i++) begin
      total++;
      if (i >= q.size() || q[i] !== exp[i]) begin bad++; $display("FAIL win0_word%0d got=%h exp=%h", i, (i < q.size()) ? q[i] : '0, exp[i]); end
    end
    total++; if (l1a_cnt !== 8'd2) begin bad++; $display("FAIL win0_cnt got=%0d exp=2", l1a_cnt); end
  endtask

  task automatic test_space();
    flush();
    total++; if (l1a_cnt !== 8'd0 || overflow !== 1'b0 || dout_valid !== 1'b0) begin bad++; $display("FAIL space_flush got=%0d/%b/%b exp=0/0/0", l1a_cnt, overflow, dout_valid); end
    dout_ready = 0; l1a_window = 4'd15; l1a = 1;
    tick();
    l1a = 0;
    tick();
    for (int i = 1; i <= 15; i++) begin din = DW'(i); din_valid = 1; tick(); end
    din_valid = 0;
    tick();
    l1a = 1;
    tick();
    l1a = 0;
    total++; if (busy !== 1'b0 || overflow !== 1'b1 || l1a_cnt !== 8'd2) begin bad++; $display("FAIL space_reject got=%b/%b/%0d exp=0/1/2", busy, overflow, l1a_cnt); end
    dout_ready = 1;
    tick();
    l1a = 1;
    tick();
    l1a = 0; dout_ready = 0;
    total++; if (busy !== 1'b0 || l1a_cnt !== 8'd3) begin bad++; $display("FAIL space_no_pop_credit got=%b/%0d exp=0/3", busy, l1a_cnt); end
    l1a = 1;
    tick();
    l1a = 0;
    total++; if (busy !== 1'b1 || l1a_cnt !== 8'd4) begin bad++; $display("FAIL space_exact_fit got=%b/%0d exp=1/4", busy, l1a_cnt); end
    tick();
    repeat (15) tick();
    tick();
    dout_ready = 1;
    repeat (20) tick();
    total++; if (dout_valid !== 1'b0) begin bad++; $display("FAIL space_drain got=%b exp=0", dout_valid); end
    total++; if (q.size() != 19) begin bad++; $display("FAIL space_count got=%0d exp=19", q.size()); end
    if (q.size() == 19) begin
      total++; if (q[1] !== mk(2'b01, 1)) begin bad++; $display("FAIL space_w1 got=%h exp=%h", q[1], mk(2'b01, 1)); end
      total++; if (q[16] !== mk(2'b10, 15)) begin bad++; $display("FAIL space_trlA got=%h exp=%h", q[16], mk(2'b10, 15)); end
      total++; if (q[17] !== mk(2'b11, 3)) begin bad++; $display("FAIL space_hdrB got=%h exp=%h", q[17], mk(2'b11, 3)); end
      total++; if (q[18] !== mk(2'b10, 96)) begin bad++; $display("FAIL space_trlB got=%h exp=%h", q[18], mk(2'b10, 96)); end
    end
  endtask

  task automatic test_l1a_during_win();
    logic [DW+1:0] exp [6];
    exp[0] = mk(2'b11, 0);
    for (int i = 1; i <= 4; i++) exp[i] = mk(2'b01, 20 + i);
    exp[5] = mk(2'b10, 4);
    dout_ready = 1;
    flush();
    l1a_window = 4'd4; l1a = 1;
    tick();
    l1a = 0;
    tick();
    for (int i = 1; i <= 4; i++) begin din = DW'(20 + i); din_valid = 1; l1a = (i == 1); tick(); end
    din_valid = 0; l1a = 0;
    repeat (5) tick();
    total++; if (overflow !== 1'b1 || l1a_cnt !== 8'd2) begin bad++; $display("FAIL win_l1a_flags got=%b/%0d exp=1/2", overflow, l1a_cnt); end
    total++; if (q.size() != 6) begin bad++; $display("FAIL win_l1a_count got=%0d exp=6", q.size()); end
    for (int i = 0; i < 6; i++) begin
      total++;
      if (i >= q.size() || q[i] !== exp[i]) begin bad++; $display("FAIL win_l1a_word%0d got=%h exp=%h", i, (i < q.size()) ? q[i] : '0, exp[i]); end
    end
    flush();
    l1a = 1;
    repeat (255) tick();
    total++; if (l1a_cnt !== 8'd255) begin bad++; $display("FAIL cnt_255 got=%0d exp=255", l1a_cnt); end
    tick();
    l1a = 0;
    total++; if (l1a_cnt !== 8'd0) begin bad++; $display("FAIL cnt_wrap got=%0d exp=0", l1a_cnt); end
    repeat (20) tick();
  endtask

  task automatic test_trig_stop();
    dout_ready = 0;
    flush();
    l1a_window = 4'd10; l1a = 1;
    tick();
    l1a = 0;
    tick();
    for (int i = 0; i < 4; i++) begin din = DW'(40 + i); din_valid = 1; l1a = (i == 1); tick(); end
    din_valid = 0; l1a = 0;
    total++; if (busy !== 1'b1 || dout_valid !== 1'b1 || overflow !== 1'b1) begin bad++; $display("FAIL stop_pre got=%b/%b/%b exp=1/1/1", busy, dout_valid, overflow); end
    trig_stop = 1; l1a = 1;
    tick();
    trig_stop = 0; l1a = 0;
    total++; if (dout_valid !== 1'b0 || busy !== 1'b0) begin bad++; $display("FAIL stop_clear got=%b/%b exp=0/0", dout_valid, busy); end
    total++; if (l1a_cnt !== 8'd0 || overflow !== 1'b0 || dout !== '0) begin bad++; $display("FAIL stop_cnt got=%0d/%b/%h exp=0/0/0", l1a_cnt, overflow, dout); end
    repeat (12) tick();
    total++; if (dout_valid !== 1'b0 || busy !== 1'b0) begin bad++; $display("FAIL stop_no_trl got=%b/%b exp=0/0", dout_valid, busy); end
  endtask

  task automatic test_async_reset();
    dout_ready = 0;
    l1a_window = 4'd5; l1a = 1;
    tick();
    l1a = 0;
    tick();
    din = DW'(9); din_valid = 1;
    tick();
    tick();
    din_valid = 0;
    #2;
    rst_n = 0;
    #1;
    total++; if (dout_valid !== 1'b0 || busy !== 1'b0 || dout !== '0 || dout_type !== 2'b00) begin bad++; $display("FAIL arst_out got=%b/%b/%h/%b exp=0/0/0/0", dout_valid, busy, dout, dout_type); end
    total++; if (l1a_cnt !== 8'd0 || overflow !== 1'b0) begin bad++; $display("FAIL arst_cnt got=%0d/%b exp=0/0", l1a_cnt, overflow); end
    rst_n = 1; l1a = 1;
    tick();
    l1a = 0;
    total++; if (busy !== 1'b1 || l1a_cnt !== 8'd1) begin bad++; $display("FAIL arst_first_l1a got=%b/%0d exp=1/1", busy, l1a_cnt); end
    tick();
    total++; if (dout_valid !== 1'b1 || dout_type !== 2'b11 || dout !== '0) begin bad++; $display("FAIL arst_hdr got=%b/%b/%h exp=1/11/0", dout_valid, dout_type, dout); end
    for (int i = 0; i < 5; i++) begin din = DW'(7); din_valid = (i < 2); tick(); end
    din_valid = 0;
    tick();
    q.delete();
    dout_ready = 1;
    repeat (6) tick();
    total++; if (q.size() != 4) begin bad++; $display("FAIL arst_count got=%0d exp=4", q.size()); end
    if (q.size() == 4) begin
      total++; if (q[2] !== mk(2'b01, 7)) begin bad++; $display("FAIL arst_data got=%h exp=%h", q[2], mk(2'b01, 7)); end
      total++; if (q[3] !== mk(2'b10, 2)) begin bad++; $display("FAIL arst_trl got=%h exp=%h", q[3], mk(2'b10, 2)); end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_window0();
    test_space();
    test_l1a_during_win();
    test_trig_stop();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/l1a_window_readout.md
L1A_WINDOW_READOUT -- requirements
Module: l1a_window_readout

Interface
REQ-001 Parameter DW, default 34, width of the delayed data frame.
REQ-002 Parameter DEPTH, default 32, readout FIFO depth in entries; power of 2, minimum 32.
REQ-003 Port clk  input  1  single clock; all logic on rising edge.
REQ-004 Port rst_n  input  1  reset, asynchronous assert, active-low.
REQ-005 Port din  input  DW  delayed frame from the pipeline delay memory.
REQ-006 Port din_valid  input  1  frame carries data (delayed valid flag).
REQ-007 Port l1a  input  1  level-1 accept pulse, one cycle.
REQ-008 Port l1a_window  input  4  window length W in frames; 0 SHALL mean 10.
REQ-009 Port trig_stop  input  1  synchronous flush.
REQ-010 Port dout  output  DW  FIFO head payload.
REQ-011 Port dout_type  output  2  head word type: 2'b11 header, 2'b01 data, 2'b10 trailer.
REQ-012 Port dout_valid  output  1  head word present.
REQ-013 Port dout_ready  input  1  consumer accepts head word.
REQ-014 Port busy  output  1  window capture in progress (state not IDLE).
REQ-015 Port l1a_cnt  output  8  event counter.
REQ-016 Port overflow  output  1  sticky: an l1a was rejected.

Function
REQ-017 FSM states: IDLE, HDR, WIN, TRL.
REQ-018 IDLE->HDR when l1a=1 and free FIFO entries >= W+2 at that cycle (n); W latched at n; otherwise stay IDLE.
REQ-019 Cycle n+1 (HDR): write header {type 11, payload zero-extended l1a_cnt value at n}; go WIN.
REQ-020 Cycles n+2..n+W+1 (WIN): per cycle, write {01, din} only if din_valid=1; count stored frames (5-bit, frame_cnt).
REQ-021 Cycle n+W+2 (TRL): write {10, payload = {l1a_cnt at n [7:0], frame_cnt[4:0]} zero-extended}; go IDLE.
REQ-022 l1a_cnt SHALL increment (mod 256, wrap 255->0) on every l1a pulse, accepted or rejected.
REQ-023 l1a while state not IDLE, or free space insufficient, SHALL be rejected: no words written, overflow set.
REQ-024 Free-space check counts occupancy at cycle n only; a pop in the same cycle is not credited.
REQ-025 FIFO first-word-fall-through: dout_valid = not empty; pop when dout_valid and dout_ready.
REQ-026 A word written into an empty FIFO SHALL appear on dout/dout_valid the following cycle.
REQ-027 Simultaneous push and pop SHALL both occur; occupancy unchanged.
REQ-028 dout and dout_type SHALL read 0 when FIFO empty.
REQ-029 Pointers wrap modulo DEPTH; full/empty distinguished by an extra pointer bit.
REQ-030 trig_stop=1 (any state) SHALL next cycle: state IDLE, FIFO empty, l1a_cnt=0, overflow=0, frame_cnt=0; l1a in that cycle ignored, not counted.
REQ-031 busy SHALL be 1 in HDR, WIN, TRL.

Reset
REQ-032 rst_n=0 SHALL immediately force state IDLE, FIFO pointers 0, dout_valid=0, dout=0, dout_type=0, busy=0, l1a_cnt=0, overflow=0, frame_cnt=0.
REQ-033 Reset mid-window SHALL discard the partial event; no trailer written after release.
REQ-034 First l1a honoured on the first rising edge with rst_n=1.

Verification
REQ-035 l1a_window=3, din_valid=1 with din=1,2,3 on window cycles, dout_ready=1 -> output: header(l1a_cnt 0), data 1,2,3, trailer frame_cnt=3; l1a_cnt=1.
REQ-036 l1a_window=0, din_valid alternating 1/0 starting 1 -> 10 window cycles, 5 data words, trailer frame_cnt=5.
REQ-037 dout_ready=0, repeated l1a with W=15 (17 words each) -> first accepted (17 entries), second rejected (15 free < 17), overflow=1, l1a_cnt=2.
REQ-038 Second l1a during WIN -> ignored, single trailer, overflow=1, l1a_cnt increments; 256 l1a pulses -> l1a_cnt wraps to 0.
REQ-039 trig_stop asserted during WIN with 5 words queued -> next cycle dout_valid=0, busy=0, l1a_cnt=0, overflow=0.
REQ-040 rst_n pulsed low asynchronously mid-WIN -> outputs cleared without clock edge; next event starts header with l1a_cnt 0.
